// File: rtl/lsu_mem_port_if.sv
// Request/response handshake plus the memory data-side bus of the load/store unit.
// slave = the LSU itself, master = the execute stage / memory side driving it.
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [29:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_wmask, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_wmask, mem_addr, mem_wd
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit in front of a word-addressed memory: lane alignment, sign/zero
// extension, and splitting of word-crossing accesses into two word accesses.
module lsu_mem_port #(
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_port_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

    function automatic logic [7:0] lane_mask(input logic [1:0] size_code, input logic [1:0] off);
        logic [7:0] base;
        case (size_code)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic is_illegal(input logic store, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] m;
        m = lane_mask(f3[1:0], off);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (store && f3[2]) ||
               (!SUPPORT_MISALIGNED && (m[7:4] != 4'b0000));
    endfunction

    // funct3[2] selects zero extension (LBU/LHU); size comes from funct3[1:0].
    function automatic logic [31:0] extend(input logic [63:0] pair, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (f3[1:0])
            2'b00:   return {{24{sh[7]  & ~f3[2]}}, sh[7:0]};
            2'b01:   return {{16{sh[15] & ~f3[2]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]  m8;
    logic [63:0] d64;
    logic        crossing;
    logic        wr_en;
    logic        we_c;
    logic [3:0]  mask_raw;
    logic [29:0] mem_addr_c;
    logic [31:0] mem_wd_c;
    logic        req_ready_c;
    logic        rsp_valid_c;

    assign m8       = lane_mask(funct3_q[1:0], addr_q[1:0]);
    assign d64      = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    assign crossing = |m8[7:4];

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        mask_raw    = 4'b0000;
        mem_addr_c  = 30'h0;
        mem_wd_c    = 32'h0;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = is_illegal(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
                    state_d  = err_d ? RESP : ACC0;
                end
            end
            ACC0: begin
                mem_addr_c = addr_q[31:2];
                mask_raw   = m8[3:0];
                mem_wd_c   = d64[31:0];
                wr_en      = store_q;
                lo_d       = bus.mem_rd;
                if (crossing) begin
                    state_d = ACC1;
                end else begin
                    rdata_d = store_q ? 32'h0 : extend({32'h0, bus.mem_rd}, funct3_q, addr_q[1:0]);
                    state_d = RESP;
                end
            end
            ACC1: begin
                // Word address wraps modulo 2^30 through the natural 30-bit add.
                mem_addr_c = addr_q[31:2] + 30'd1;
                mask_raw   = m8[7:4];
                mem_wd_c   = d64[63:32];
                wr_en      = store_q;
                rdata_d    = store_q ? 32'h0 : extend({bus.mem_rd, lo_q}, funct3_q, addr_q[1:0]);
                state_d    = RESP;
            end
            default: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
        endcase
    end

    assign we_c          = wr_en & ~rst;
    assign bus.mem_we    = we_c;
    assign bus.mem_wmask = we_c ? mask_raw : 4'b0000;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wd    = mem_wd_c;
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            lo_q     <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: stimulus pushes expected responses, a negedge
// monitor records memory-side activity per transaction and checks each response.
module tb_lsu_mem_port;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_acc;
        logic        we;
        logic [29:0] a0, a1;
        logic [3:0]  m0, m1;
        logic [31:0] wd0, wd1;
    } exp_t;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] d;
    } pl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_port_if bus ();
    lsu_mem_port_if bus1 ();

    lsu_mem_port #(.SUPPORT_MISALIGNED(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    lsu_mem_port #(.SUPPORT_MISALIGNED(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // 64-word memory indexed by mem_addr[5:0]; tests reload the words they touch.
    logic [31:0] mem [64];
    pl_t         pl_q[$];

    always_comb bus.mem_rd  = mem[bus.mem_addr[5:0]];
    always_comb bus1.mem_rd = mem[bus1.mem_addr[5:0]];

    initial begin
        pl_t p;
        forever begin
            @(negedge clk);
            if (bus.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wmask[b]) mem[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wd[8*b +: 8];
            while (pl_q.size() > 0) begin
                p = pl_q.pop_front();
                mem[p.idx] <= p.d;
            end
        end
    end

    int   n_vec = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   target = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor state
    bit          trk = 0;
    bit          lat_done = 0;
    bit          prev_v = 0;
    int          cyc = 0;
    int          lat = 0;
    int          nacc = 0;
    int          stray_we = 0;
    int          unstable = 0;
    int          we1_cnt = 0;
    logic [31:0] prev_rd;
    logic        prev_err;
    logic [29:0] oa  [2];
    logic [3:0]  om  [2];
    logic [31:0] owd [2];
    logic        owe [2];

    initial begin
        exp_t e;
        logic [29:0] ea;
        logic [3:0]  em;
        logic [31:0] ewd;
        forever begin
            @(negedge clk);
            if (bus1.mem_we) we1_cnt++;
            if (rst) begin
                trk    = 0;
                prev_v = 0;
            end else begin
                if (trk) begin
                    cyc++;
                    if (bus.rsp_valid && !lat_done) begin
                        lat      = cyc;
                        lat_done = 1;
                    end
                    if (!bus.rsp_valid && !bus.req_ready) begin
                        if (nacc < 2) begin
                            oa[nacc]  = bus.mem_addr;
                            om[nacc]  = bus.mem_wmask;
                            owd[nacc] = bus.mem_wd;
                            owe[nacc] = bus.mem_we;
                        end
                        nacc++;
                    end else if (bus.mem_we) begin
                        stray_we++;
                    end
                end else if (bus.mem_we) begin
                    stray_we++;
                end
                if (bus.rsp_valid) begin
                    if (bus.req_ready) unstable++;
                    if (prev_v && (bus.rsp_rdata !== prev_rd || bus.rsp_err !== prev_err)) unstable++;
                    prev_v   = 1;
                    prev_rd  = bus.rsp_rdata;
                    prev_err = bus.rsp_err;
                    if (bus.rsp_ready) begin
                        if (sb_q.size() == 0) begin
                            n_vec++;
                            n_fail++;
                            $display("FAIL unexpected_rsp: got a response, expected none");
                        end else begin
                            e = sb_q.pop_front();
                            check($sformatf("v%0d.rdata", e.id), bus.rsp_rdata, e.rdata);
                            check($sformatf("v%0d.err", e.id), 32'(bus.rsp_err), 32'(e.err));
                            check($sformatf("v%0d.latency", e.id), 32'(lat), 32'(e.lat));
                            check($sformatf("v%0d.accesses", e.id), 32'(nacc), 32'(e.n_acc));
                            check($sformatf("v%0d.stray_we", e.id), 32'(stray_we), 32'd0);
                            check($sformatf("v%0d.rsp_stable", e.id), 32'(unstable), 32'd0);
                            for (int i = 0; i < 2; i++) begin
                                if (i < e.n_acc && i < nacc) begin
                                    ea  = (i == 0) ? e.a0 : e.a1;
                                    em  = (i == 0) ? e.m0 : e.m1;
                                    ewd = (i == 0) ? e.wd0 : e.wd1;
                                    check($sformatf("v%0d.acc%0d.addr", e.id, i), {2'b00, oa[i]}, {2'b00, ea});
                                    check($sformatf("v%0d.acc%0d.mask", e.id, i), {28'h0, om[i]}, {28'h0, em});
                                    check($sformatf("v%0d.acc%0d.we", e.id, i), 32'(owe[i]), 32'(e.we));
                                    if (e.we) check($sformatf("v%0d.acc%0d.wd", e.id, i), owd[i], ewd);
                                end
                            end
                        end
                        trk    = 0;
                        prev_v = 0;
                        n_done++;
                    end
                end
                if (bus.req_valid && bus.req_ready) begin
                    trk      = 1;
                    cyc      = 0;
                    lat_done = 0;
                    nacc     = 0;
                    stray_we = 0;
                    unstable = 0;
                end
            end
        end
    end

    function automatic exp_t mk(input int id, input logic [31:0] rdata, input logic err, input int l,
                                input int n, input logic we,
                                input logic [29:0] a0, input logic [3:0] m0, input logic [31:0] wd0,
                                input logic [29:0] a1, input logic [3:0] m1, input logic [31:0] wd1);
        exp_t e;
        e.id = id; e.rdata = rdata; e.err = err; e.lat = l; e.n_acc = n; e.we = we;
        e.a0 = a0; e.m0 = m0; e.wd0 = wd0; e.a1 = a1; e.m1 = m1; e.wd1 = wd1;
        return e;
    endfunction

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        pl_t p;
        p.idx = idx;
        p.d   = d;
        pl_q.push_back(p);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (n_done < target && k < 30) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (n_done < target) begin
            n_vec++;
            n_fail++;
            $display("FAIL rsp_timeout: got %0d responses, expected %0d", n_done, target);
        end
    endtask

    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input exp_t e);
        sb_q.push_back(e);
        target++;
        issue(st, f3, a, wd);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.rsp_ready = 1;
        bus1.req_valid = 0; bus1.req_store = 0; bus1.req_funct3 = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
        bus1.rsp_ready = 1;
        for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst.rsp_rdata", bus.rsp_rdata,      32'h0);
        check("rst.mem_we",    32'(bus.mem_we),    32'd0);
        check("rst.mem_wmask", 32'(bus.mem_wmask), 32'd0);
        check("rst.mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst.mem_wd",    bus.mem_wd,         32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);

        // SW aligned
        run(1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF,
            mk(1, 32'h0, 1'b0, 2, 1, 1'b1, 30'h1000, 4'b1111, 32'hDEAD_BEEF, 30'h0, 4'b0, 32'h0));
        check("v1.mem_word", mem[0], 32'hDEAD_BEEF);

        // Loads from word 5000
        preload(6'h08, 32'h8475_5779);
        preload(6'h09, 32'h1122_3344);
        settle();
        run(1'b0, 3'b000, 32'h0000_4E23, 32'h0,
            mk(2, 32'hFFFF_FF84, 1'b0, 2, 1, 1'b0, 30'd5000, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0));
        run(1'b0, 3'b100, 32'h0000_4E23, 32'h0,
            mk(3, 32'h0000_0084, 1'b0, 2, 1, 1'b0, 30'd5000, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0));
        run(1'b0, 3'b001, 32'h0000_4E20, 32'h0,
            mk(4, 32'h0000_5779, 1'b0, 2, 1, 1'b0, 30'd5000, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0));
        run(1'b0, 3'b010, 32'h0000_4E22, 32'h0,
            mk(5, 32'h3344_8475, 1'b0, 3, 2, 1'b0, 30'd5000, 4'b0, 32'h0, 30'd5001, 4'b0, 32'h0));

        // SH crossing a word boundary
        preload(6'h00, 32'h1111_1111);
        preload(6'h01, 32'h2222_2222);
        settle();
        run(1'b1, 3'b001, 32'h0000_4003, 32'h0000_ABCD,
            mk(6, 32'h0, 1'b0, 3, 2, 1'b1, 30'h1000, 4'b1000, 32'hCD00_0000, 30'h1001, 4'b0001, 32'h0000_00AB));
        check("v6.mem_lo", mem[0], 32'hCD11_1111);
        check("v6.mem_hi", mem[1], 32'h2222_22AB);

        // Illegal encodings
        run(1'b0, 3'b011, 32'h0000_4000, 32'h0,
            mk(7, 32'h0, 1'b1, 1, 0, 1'b0, 30'h0, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0));
        run(1'b1, 3'b100, 32'h0000_4000, 32'h1234_5678,
            mk(8, 32'h0, 1'b1, 1, 0, 1'b0, 30'h0, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0));
        check("v8.mem_word", mem[0], 32'hCD11_1111);

        // LW wrapping past the top of the address space
        preload(6'h3F, 32'hAABB_CCDD);
        preload(6'h00, 32'h1122_3344);
        settle();
        run(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,
            mk(9, 32'h3344_AABB, 1'b0, 3, 2, 1'b0, 30'h3FFF_FFFF, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0));

        // Reset raised during ACC0 of an SW
        preload(6'h00, 32'h5555_5555);
        settle();
        issue(1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mid.mem_wmask", 32'(bus.mem_wmask), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #1;
        check("rst_mid.mem_word", mem[0], 32'h5555_5555);

        // Response back-pressure
        bus.rsp_ready = 1'b0;
        sb_q.push_back(mk(10, 32'h8475_5779, 1'b0, 2, 1, 1'b0, 30'd5000, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0));
        target++;
        issue(1'b0, 3'b010, 32'h0000_4E20, 32'h0);
        k = 0;
        while (!bus.rsp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall%0d.req_ready", i), 32'(bus.req_ready), 32'd0);
            check($sformatf("stall%0d.rsp_rdata", i), bus.rsp_rdata, 32'h8475_5779);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_done();

        // SUPPORT_MISALIGNED = 0 rejects a crossing LW without touching memory
        bus1.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus1.req_valid  = 1'b1;
        bus1.req_store  = 1'b0;
        bus1.req_funct3 = 3'b010;
        bus1.req_addr   = 32'h0000_4E22;
        @(posedge clk);
        #1 bus1.req_valid = 1'b0;
        k = 1;
        while (!bus1.rsp_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("nomis.latency",   32'(k),             32'd1);
        check("nomis.rsp_err",   32'(bus1.rsp_err),  32'd1);
        check("nomis.rsp_rdata", bus1.rsp_rdata,     32'h0);
        check("nomis.req_ready", 32'(bus1.req_ready), 32'd0);
        bus1.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("nomis.mem_we_cnt", 32'(we1_cnt), 32'd0);
        check("nomis.idle", 32'(bus1.req_ready), 32'd1);

        check("sb.drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
